// File: rtl/rr_sel4_pkg.sv
// rr_sel4 shared constants and types.
// Imported by the picker, the interface and the top.
package rr_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

endpackage

// File: rtl/rr_sel4_if.sv
// Handshake bundle between the requesting channels,
// the select generator and the consumer of mux output y.
interface rr_sel4_if;
    import rr_pkg::*;

    logic [N_CH-1:0]  req;
    logic             out_ready;
    logic [SEL_W-1:0] s;
    logic [N_CH-1:0]  grant;
    logic             out_valid;
    logic             last;

    modport master (
        input  req,
        input  out_ready,
        output s,
        output grant,
        output out_valid,
        output last
    );

    modport slave (
        output req,
        output out_ready,
        input  s,
        input  grant,
        input  out_valid,
        input  last
    );

endinterface

// File: rtl/rr_sel4_pick4.sv
// Rotating-priority picker: first set req at or above ptr,
// wrapping mod 4.
module rr_pick4
    import rr_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest wins.
    always_comb begin
        idx  = ptr;
        cand = '0;
        any  = |req;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_sel4.sv
// Round-robin select generator driving mux4_8 s, holding
// each grant until accepted, up to BURST transfers per grant.
module rr_sel4
    import rr_pkg::*;
#(
    parameter int BURST = 1
) (
    input  logic      clk,
    input  logic      reset,
    rr_sel4_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST - 1);

    state_t           state, state_nx;
    logic [SEL_W-1:0] s_q, s_nx;
    logic [SEL_W-1:0] ptr_q, ptr_nx;
    logic [N_CH-1:0]  grant_q, grant_nx;
    logic             valid_q, valid_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;

    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             xfer;
    logic             at_end;

    assign xfer   = valid_q && bus.out_ready;
    assign at_end = (cnt_q == CNT_MAX) || !bus.req[s_q];

    // On release the owner drops to lowest priority; idle
    // arbitration starts from the stored pointer.
    assign pick_ptr = (state == GRANT) ? s_q + SEL_W'(1)
                                       : ptr_q;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state: grant, burst count, release and re-pick.
    always_comb begin
        state_nx = state;
        s_nx     = s_q;
        ptr_nx   = ptr_q;
        grant_nx = grant_q;
        valid_nx = valid_q;
        cnt_nx   = cnt_q;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    s_nx     = pick_idx;
                    grant_nx = N_CH'(1) << pick_idx;
                    cnt_nx   = '0;
                    valid_nx = 1'b1;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (!at_end) begin
                        cnt_nx = cnt_q + CNT_W'(1);
                    end else begin
                        ptr_nx = s_q + SEL_W'(1);
                        cnt_nx = '0;
                        if (pick_any) begin
                            s_nx     = pick_idx;
                            grant_nx = N_CH'(1) << pick_idx;
                        end else begin
                            valid_nx = 1'b0;
                            grant_nx = '0;
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            s_q     <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            s_q     <= s_nx;
            ptr_q   <= ptr_nx;
            grant_q <= grant_nx;
            valid_q <= valid_nx;
            cnt_q   <= cnt_nx;
        end
    end

    assign bus.s         = s_q;
    assign bus.grant     = grant_q;
    assign bus.out_valid = valid_q;
    assign bus.last      = valid_q && at_end;

endmodule

// File: tb/tb_rr_sel4.sv
// Scoreboard bench for rr_sel4 at BURST = 1, 3 and 4,
// sharing one random/directed stimulus stream.
module tb_rr_sel4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_d;
    logic       rdy_d;

    always #5 clk = ~clk;

    rr_sel4_if b0 ();
    rr_sel4_if b1 ();
    rr_sel4_if b2 ();

    assign b0.req = req_d;
    assign b1.req = req_d;
    assign b2.req = req_d;
    assign b0.out_ready = rdy_d;
    assign b1.out_ready = rdy_d;
    assign b2.out_ready = rdy_d;

    rr_sel4 #(.BURST(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
    rr_sel4 #(.BURST(3)) u1 (.clk(clk), .reset(reset), .bus(b1));
    rr_sel4 #(.BURST(4)) u2 (.clk(clk), .reset(reset), .bus(b2));

    logic [2:0]       o_v, o_l;
    logic [2:0][1:0]  o_s;
    logic [2:0][3:0]  o_g;

    assign o_v = {b2.out_valid, b1.out_valid, b0.out_valid};
    assign o_l = {b2.last, b1.last, b0.last};
    assign o_s = {b2.s, b1.s, b0.s};
    assign o_g = {b2.grant, b1.grant, b0.grant};

    typedef struct {
        logic [2:0]      v;
        logic [2:0]      l;
        logic [2:0][1:0] s;
        logic [2:0][3:0] g;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int BL[3] = '{1, 3, 4};
    bit busy[3];
    int owner[3];
    int nxt[3];
    int used[3];

    int total  = 0;
    int passed = 0;

    task automatic chk(string name, int i, int act, int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s[B=%0d] actual=%0d required=%0d",
                      name, BL[i], act, expv);
    endtask

    function automatic int pick(logic [3:0] r, int st);
        for (int k = 0; k < 4; k++) begin
            if (r[(st + k) % 4]) return (st + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            busy[i]  = 1'b0;
            owner[i] = 0;
            nxt[i]   = 0;
            used[i]  = 0;
        end
    endtask

    // Drive one cycle, record what the DUTs should show now,
    // then advance the reference model across the next edge.
    task automatic cycle(input logic [3:0] r, input logic rd);
        exp_t x;
        int   p;
        @(negedge clk);
        #1;
        req_d = r;
        rdy_d = rd;
        for (int i = 0; i < 3; i++) begin
            x.v[i] = busy[i];
            x.s[i] = 2'(owner[i]);
            x.g[i] = busy[i] ? 4'(1 << owner[i]) : 4'b0000;
            x.l[i] = busy[i] &&
                     (used[i] == BL[i] - 1 || !r[owner[i]]);
        end
        q.push_back(x);
        for (int i = 0; i < 3; i++) begin
            if (!busy[i]) begin
                p = pick(r, nxt[i]);
                if (p >= 0) begin
                    owner[i] = p;
                    used[i]  = 0;
                    busy[i]  = 1'b1;
                end
            end else if (rd) begin
                if (used[i] + 1 < BL[i] && r[owner[i]]) begin
                    used[i]++;
                end else begin
                    nxt[i] = (owner[i] + 1) % 4;
                    p = pick(r, nxt[i]);
                    if (p >= 0) begin
                        owner[i] = p;
                        used[i]  = 0;
                    end else begin
                        busy[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_cleared(string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_valid"}, i, int'(o_v[i]), 0);
            chk({tag, "_grant"}, i, int'(o_g[i]), 0);
            chk({tag, "_s"}, i, int'(o_s[i]), 0);
            chk({tag, "_last"}, i, int'(o_l[i]), 0);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear
    // without waiting for a clock.
    task automatic do_reset();
        #2;
        req_d = 4'b0000;
        rdy_d = 1'b0;
        reset = 1'b1;
        #1;
        check_cleared("rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare every observed cycle against the queue.
    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk("valid", i, int'(o_v[i]), int'(e.v[i]));
                chk("s", i, int'(o_s[i]), int'(e.s[i]));
                chk("grant", i, int'(o_g[i]), int'(e.g[i]));
                chk("last", i, int'(o_l[i]), int'(e.l[i]));
            end
        end
    end

    initial begin
        reset = 1'b1;
        req_d = 4'b0000;
        rdy_d = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #3;
        check_cleared("init");
        @(negedge clk);
        reset = 1'b0;

        repeat (8) cycle(4'b1111, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);

        repeat (5) cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        repeat (3) cycle(4'b0100, 1'b0);
        do_reset();
        repeat (2) cycle(4'b1000, 1'b0);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        repeat (12) cycle(4'b0011, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);

        repeat (2) cycle(4'b1001, 1'b1);
        repeat (3) cycle(4'b1000, 1'b1);
        repeat (4) cycle(4'b1001, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);

        cycle(4'b1000, 1'b0);
        cycle(4'b1001, 1'b1);
        cycle(4'b1001, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            cycle(4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #3;
        chk("drain", 0, q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
